// File: rtl/rggen_register_bus_arbiter.sv
// Round-robin arbiter that shares one register-bus target between HOSTS requesters.
// Each granted request is captured and replayed until the target completes or the watchdog expires.
module rggen_register_bus_arbiter #(
  parameter int HOSTS          = 2,
  parameter int ADDRESS_WIDTH  = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 0,
  localparam int STROBE_WIDTH  = BUS_WIDTH / 8
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [HOSTS-1:0]                i_host_valid,
  input  logic [HOSTS-1:0]                i_host_write,
  input  logic [HOSTS*ADDRESS_WIDTH-1:0]  i_host_address,
  input  logic [HOSTS*BUS_WIDTH-1:0]      i_host_write_data,
  input  logic [HOSTS*STROBE_WIDTH-1:0]   i_host_strobe,
  output logic [HOSTS-1:0]                o_host_ready,
  output logic [HOSTS*2-1:0]              o_host_status,
  output logic [HOSTS*BUS_WIDTH-1:0]      o_host_read_data,
  output logic                            o_bus_valid,
  output logic                            o_bus_write,
  output logic [ADDRESS_WIDTH-1:0]        o_bus_address,
  output logic [BUS_WIDTH-1:0]            o_bus_write_data,
  output logic [STROBE_WIDTH-1:0]         o_bus_strobe,
  input  logic                            i_bus_ready,
  input  logic [1:0]                      i_bus_status,
  input  logic [BUS_WIDTH-1:0]            i_bus_read_data
);

  localparam int IDX_W = (HOSTS > 1) ? $clog2(HOSTS) : 1;
  localparam int WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [1:0] SLAVE_ERROR = 2'b10;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          grant_q, grant_d;
  logic [IDX_W-1:0]          ptr_q, ptr_d;
  logic [WD_W-1:0]           wd_q, wd_d;
  logic                      write_q, write_d;
  logic [ADDRESS_WIDTH-1:0]  address_q, address_d;
  logic [BUS_WIDTH-1:0]      write_data_q, write_data_d;
  logic [STROBE_WIDTH-1:0]   strobe_q, strobe_d;

  logic [ADDRESS_WIDTH-1:0]  host_address [HOSTS];
  logic [BUS_WIDTH-1:0]      host_write_data [HOSTS];
  logic [STROBE_WIDTH-1:0]   host_strobe [HOSTS];

  logic [2*HOSTS-1:0]        valid_rot;
  logic [IDX_W:0]            sel_sum;
  logic [IDX_W-1:0]          sel_offset;
  logic [IDX_W-1:0]          sel_idx;
  logic                      sel_found;
  logic [IDX_W-1:0]          next_ptr;
  logic                      timeout;
  logic                      done;

  for (genvar h = 0; h < HOSTS; h++) begin : g_unpack
    assign host_address[h]    = i_host_address[h*ADDRESS_WIDTH+:ADDRESS_WIDTH];
    assign host_write_data[h] = i_host_write_data[h*BUS_WIDTH+:BUS_WIDTH];
    assign host_strobe[h]     = i_host_strobe[h*STROBE_WIDTH+:STROBE_WIDTH];
  end

  // Rotate the valid vector so the priority pointer lands at bit 0, then take the first set bit.
  always_comb begin
    valid_rot  = {i_host_valid, i_host_valid} >> ptr_q;
    sel_found  = 1'b0;
    sel_offset = '0;
    for (int i = 0; i < HOSTS; i++) begin
      if (!sel_found && valid_rot[i]) begin
        sel_found  = 1'b1;
        sel_offset = IDX_W'(i);
      end
    end
    sel_sum = {1'b0, ptr_q} + {1'b0, sel_offset};
    if (sel_sum >= (IDX_W+1)'(HOSTS)) begin
      sel_sum = sel_sum - (IDX_W+1)'(HOSTS);
    end
    sel_idx = sel_sum[IDX_W-1:0];
  end

  assign next_ptr = (grant_q == IDX_W'(HOSTS - 1)) ? '0 : grant_q + 1'b1;
  assign timeout  = (TIMEOUT_CYCLES > 0) && (wd_q == WD_LAST);
  assign done     = (state_q == BUSY) && (i_bus_ready || timeout);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    wd_d         = wd_q;
    write_d      = write_q;
    address_d    = address_q;
    write_data_d = write_data_q;
    strobe_d     = strobe_q;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          grant_d      = sel_idx;
          write_d      = i_host_write[sel_idx];
          address_d    = host_address[sel_idx];
          write_data_d = host_write_data[sel_idx];
          strobe_d     = host_strobe[sel_idx];
          state_d      = BUSY;
        end
      end
      BUSY: begin
        if (done) begin
          ptr_d   = next_ptr;
          wd_d    = '0;
          state_d = IDLE;
        end else if (TIMEOUT_CYCLES > 0) begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      ptr_q        <= '0;
      wd_q         <= '0;
      write_q      <= 1'b0;
      address_q    <= '0;
      write_data_q <= '0;
      strobe_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      ptr_q        <= ptr_d;
      wd_q         <= wd_d;
      write_q      <= write_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      strobe_q     <= strobe_d;
    end
  end

  assign o_bus_valid      = (state_q == BUSY);
  assign o_bus_write      = write_q;
  assign o_bus_address    = address_q;
  assign o_bus_write_data = write_data_q;
  assign o_bus_strobe     = strobe_q;

  // Response slices stay zero except for the granted host in its completion cycle.
  always_comb begin
    o_host_ready     = '0;
    o_host_status    = '0;
    o_host_read_data = '0;
    if (done) begin
      for (int h = 0; h < HOSTS; h++) begin
        if (grant_q == IDX_W'(h)) begin
          o_host_ready[h] = 1'b1;
          if (i_bus_ready) begin
            o_host_status[h*2+:2]                = i_bus_status;
            o_host_read_data[h*BUS_WIDTH+:BUS_WIDTH] = i_bus_read_data;
          end else begin
            o_host_status[h*2+:2] = SLAVE_ERROR;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rggen_register_bus_arbiter.sv
// Scoreboard bench for rggen_register_bus_arbiter: two hosts, 4-cycle watchdog,
// a scripted target model and a monitor that checks every bus and host response.
module tb_rggen_register_bus_arbiter;

  localparam int H  = 2;
  localparam int AW = 8;
  localparam int BW = 32;
  localparam int SW = BW / 8;

  logic            clk;
  logic            rst;
  logic [H-1:0]    host_valid;
  logic [H-1:0]    host_write;
  logic [H*AW-1:0] host_address;
  logic [H*BW-1:0] host_write_data;
  logic [H*SW-1:0] host_strobe;
  logic [H-1:0]    host_ready;
  logic [H*2-1:0]  host_status;
  logic [H*BW-1:0] host_read_data;
  logic            bus_valid;
  logic            bus_write;
  logic [AW-1:0]   bus_address;
  logic [BW-1:0]   bus_write_data;
  logic [SW-1:0]   bus_strobe;
  logic            bus_ready;
  logic [1:0]      bus_status;
  logic [BW-1:0]   bus_read_data;

  rggen_register_bus_arbiter #(
    .HOSTS(H), .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .TIMEOUT_CYCLES(4)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_host_valid(host_valid), .i_host_write(host_write),
    .i_host_address(host_address), .i_host_write_data(host_write_data),
    .i_host_strobe(host_strobe),
    .o_host_ready(host_ready), .o_host_status(host_status),
    .o_host_read_data(host_read_data),
    .o_bus_valid(bus_valid), .o_bus_write(bus_write), .o_bus_address(bus_address),
    .o_bus_write_data(bus_write_data), .o_bus_strobe(bus_strobe),
    .i_bus_ready(bus_ready), .i_bus_status(bus_status), .i_bus_read_data(bus_read_data)
  );

  typedef struct {
    int          host;
    logic [1:0]  status;
    logic [31:0] rdata;
    int          cyc;
  } hexp_t;

  typedef struct {
    logic        write;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strobe;
  } bexp_t;

  hexp_t       hq[$];
  bexp_t       bq[$];
  hexp_t       mon_e;
  bexp_t       mon_b;
  int          compared;
  int          mismatched;
  int          cyc;
  int          pend [H];
  logic [H-1:0] rdy_seen;
  bit          prev_rdy;
  int          tgt_wait;
  logic [1:0]  tgt_status;
  logic [31:0] tgt_rdata;
  int          busy_cnt;
  int          c0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares bus fields while a transfer is active and pops host responses on ready.
  always @(negedge clk) begin
    if (rst) begin
      prev_rdy = 1'b0;
      rdy_seen = '0;
    end else begin
      if (prev_rdy) check("bus_idle_after_done", {63'd0, bus_valid}, 64'd0);
      if (bus_valid) begin
        if (bq.size() == 0) begin
          check("bus_unexpected", 64'd1, 64'd0);
        end else begin
          mon_b = bq[0];
          check("bus_write", {63'd0, bus_write}, {63'd0, mon_b.write});
          check("bus_address", {56'd0, bus_address}, {56'd0, mon_b.addr});
          check("bus_write_data", {32'd0, bus_write_data}, {32'd0, mon_b.wdata});
          check("bus_strobe", {60'd0, bus_strobe}, {60'd0, mon_b.strobe});
        end
      end
      if (host_ready != '0) begin
        if (hq.size() == 0) begin
          check("ready_unexpected", {62'd0, host_ready}, 64'd0);
        end else begin
          mon_e = hq.pop_front();
          check("ready_onehot", {62'd0, host_ready}, 64'd1 << mon_e.host);
          check("host_status", {62'd0, host_status[mon_e.host*2+:2]}, {62'd0, mon_e.status});
          check("host_read_data", {32'd0, host_read_data[mon_e.host*BW+:BW]}, {32'd0, mon_e.rdata});
          check("other_status_zero", {62'd0, host_status[(1-mon_e.host)*2+:2]}, 64'd0);
          check("other_rdata_zero", {32'd0, host_read_data[(1-mon_e.host)*BW+:BW]}, 64'd0);
          if (mon_e.cyc >= 0) check("ready_latency", 64'(cyc), 64'(mon_e.cyc));
        end
        if (bq.size() > 0) void'(bq.pop_front());
      end else begin
        check("idle_status_zero", {60'd0, host_status}, 64'd0);
        check("idle_rdata_zero", host_read_data, 64'd0);
      end
      prev_rdy = (host_ready != '0);
      rdy_seen = host_ready;
    end
  end

  // One cycle of host release and target response, driven just after the clock edge.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int h = 0; h < H; h++) begin
      if (rdy_seen[h]) begin
        pend[h]--;
        if (pend[h] <= 0) begin
          pend[h] = 0;
          host_valid[h] = 1'b0;
        end
      end
    end
    if (bus_valid) begin
      busy_cnt++;
      bus_ready = (tgt_wait >= 0) && (busy_cnt == tgt_wait + 1);
    end else begin
      busy_cnt  = 0;
      bus_ready = 1'b0;
    end
    bus_status    = bus_ready ? tgt_status : 2'b01;
    bus_read_data = bus_ready ? tgt_rdata : 32'hDEAD_BEEF;
  endtask

  task automatic issue(int h, logic w, logic [7:0] a, logic [31:0] d, logic [3:0] s, int n);
    host_write[h]             = w;
    host_address[h*AW+:AW]    = a;
    host_write_data[h*BW+:BW] = d;
    host_strobe[h*SW+:SW]     = s;
    host_valid[h]             = 1'b1;
    pend[h]                   = pend[h] + n;
  endtask

  task automatic expect_txn(int h, logic [1:0] st, logic [31:0] rd, int c);
    hexp_t e;
    bexp_t b;
    e.host = h; e.status = st; e.rdata = rd; e.cyc = c;
    b.write = host_write[h]; b.addr = host_address[h*AW+:AW];
    b.wdata = host_write_data[h*BW+:BW]; b.strobe = host_strobe[h*SW+:SW];
    hq.push_back(e);
    bq.push_back(b);
  endtask

  task automatic wait_done(string name);
    for (int i = 0; i < 60 && hq.size() > 0; i++) tick();
    if (hq.size() > 0) begin
      check({"wait_", name}, 64'(hq.size()), 64'd0);
      hq.delete();
      bq.delete();
    end
  endtask

  initial begin
    compared = 0; mismatched = 0; cyc = 0;
    pend[0] = 0; pend[1] = 0;
    rst = 1'b1;
    host_valid = '0; host_write = '0; host_address = '0;
    host_write_data = '0; host_strobe = '0;
    bus_ready = 1'b0; bus_status = 2'b00; bus_read_data = '0;
    tgt_wait = 0; tgt_status = 2'b00; tgt_rdata = '0; busy_cnt = 0;
    prev_rdy = 1'b0; rdy_seen = '0;

    repeat (3) tick();
    check("rst_bus_valid", {63'd0, bus_valid}, 64'd0);
    check("rst_host_ready", {62'd0, host_ready}, 64'd0);
    check("rst_bus_address", {56'd0, bus_address}, 64'd0);
    check("rst_bus_write_data", {32'd0, bus_write_data}, 64'd0);

    // Both hosts request together out of reset: host 0 first, then host 1.
    tgt_wait = 0; tgt_status = 2'b00; tgt_rdata = 32'h0000_00AA;
    issue(0, 1'b1, 8'h20, 32'h1111_0000, 4'h3, 1);
    issue(1, 1'b0, 8'h24, 32'h2222_0000, 4'hC, 1);
    expect_txn(0, 2'b00, 32'h0000_00AA, -1);
    expect_txn(1, 2'b00, 32'h0000_00AA, -1);
    tick();
    rst = 1'b0;
    wait_done("both");

    // Both held for two transactions each: grants alternate 0,1,0,1.
    tgt_wait = 1; tgt_status = 2'b01; tgt_rdata = 32'h0BAD_F00D;
    issue(0, 1'b0, 8'h30, 32'h0, 4'hF, 2);
    issue(1, 1'b1, 8'h34, 32'hCAFE_0001, 4'h1, 2);
    expect_txn(0, 2'b01, 32'h0BAD_F00D, -1);
    expect_txn(1, 2'b01, 32'h0BAD_F00D, -1);
    expect_txn(0, 2'b01, 32'h0BAD_F00D, -1);
    expect_txn(1, 2'b01, 32'h0BAD_F00D, -1);
    wait_done("alternate");

    // Host 0 write, target ready one cycle after bus valid: idle cycle, two busy cycles.
    tgt_wait = 1; tgt_status = 2'b00; tgt_rdata = 32'h0;
    c0 = cyc;
    issue(0, 1'b1, 8'h10, 32'hA5A5_0001, 4'hF, 1);
    expect_txn(0, 2'b00, 32'h0, c0 + 2);
    wait_done("write0");

    // Host 1 read returning data and status 11.
    tgt_wait = 0; tgt_status = 2'b11; tgt_rdata = 32'h1234_5678;
    c0 = cyc;
    issue(1, 1'b0, 8'h44, 32'h0, 4'hF, 1);
    expect_txn(1, 2'b11, 32'h1234_5678, c0 + 1);
    wait_done("read1");

    // Target never responds: watchdog completes on the 4th busy cycle with SLAVE_ERROR.
    tgt_wait = -1; tgt_status = 2'b00; tgt_rdata = 32'h5555_AAAA;
    c0 = cyc;
    issue(0, 1'b0, 8'h50, 32'h0, 4'hF, 1);
    expect_txn(0, 2'b10, 32'h0, c0 + 4);
    wait_done("timeout");

    // Target ready on the same cycle the watchdog fires: target status wins.
    tgt_wait = 3; tgt_status = 2'b00; tgt_rdata = 32'h7777_0007;
    c0 = cyc;
    issue(0, 1'b0, 8'h54, 32'h0, 4'hF, 1);
    expect_txn(0, 2'b00, 32'h7777_0007, c0 + 4);
    wait_done("ready_at_timeout");

    // Reset in the 2nd busy cycle aborts host 0; held host 1 is served after release.
    tgt_wait = -1;
    issue(0, 1'b1, 8'h60, 32'h6060_6060, 4'hF, 1);
    bq.push_back('{write: 1'b1, addr: 8'h60, wdata: 32'h6060_6060, strobe: 4'hF});
    for (int i = 0; i < 10 && !bus_valid; i++) tick();
    check("abort_bus_started", {63'd0, bus_valid}, 64'd1);
    issue(1, 1'b0, 8'h68, 32'h0, 4'h5, 1);
    tick();
    #1 rst = 1'b1;
    #1;
    check("abort_bus_valid", {63'd0, bus_valid}, 64'd0);
    check("abort_host_ready", {62'd0, host_ready}, 64'd0);
    hq.delete();
    bq.delete();
    pend[0] = 0;
    host_valid[0] = 1'b0;
    tgt_wait = 0; tgt_status = 2'b00; tgt_rdata = 32'h0000_6868;
    expect_txn(1, 2'b00, 32'h0000_6868, -1);
    tick();
    tick();
    rst = 1'b0;
    wait_done("after_reset");
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
